// File: rtl/onehot_decoder_scan.sv
// Registered binary-to-one-hot select decoder with latched direct-select and autonomous scan modes.
// Optional feature macro: SCAN_SKIP_MASK_EN adds i_skip_mask to exclude indices from the scan.
module onehot_decoder_scan #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DWELL_W = 8,
    localparam int unsigned OUT_W  = 2**ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_mode,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_addr_in,
    input  logic [DWELL_W-1:0] i_dwell,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [OUT_W-1:0]   i_skip_mask,
`endif
    output logic [OUT_W-1:0]   o_sel_out,
    output logic [ADDR_W-1:0]  o_sel_idx,
    output logic               o_valid_out,
    output logic               o_wrap
);

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

    state_e               r_state, w_state_d;
    logic [OUT_W-1:0]     r_sel_out;
    logic [ADDR_W-1:0]    r_sel_idx, w_idx_d;
    logic                 r_valid, w_act_d;
    logic                 r_wrap, w_wrap_d;
    logic [DWELL_W-1:0]   r_cnt, w_cnt_d;
    logic [DWELL_W-1:0]   r_dwell, w_dwell_d;

    logic [OUT_W-1:0]     w_mask;
    logic                 w_first_found, w_next_found;
    logic [ADDR_W-1:0]    w_first_idx, w_next_idx;

`ifdef SCAN_SKIP_MASK_EN
    assign w_mask = i_skip_mask;
`else
    assign w_mask = '0;
`endif

    // Lowest unmasked index: descending sweep so the lowest hit is written last.
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = '0;
        for (int k = OUT_W - 1; k >= 0; k--) begin
            if (!w_mask[k]) begin
                w_first_found = 1'b1;
                w_first_idx   = ADDR_W'(k);
            end
        end
    end

    // Next unmasked index after the current one, modulo OUT_W; offset OUT_W revisits itself.
    always_comb begin
        w_next_found = 1'b0;
        w_next_idx   = '0;
        for (int k = OUT_W; k >= 1; k--) begin
            if (!w_mask[r_sel_idx + ADDR_W'(k)]) begin
                w_next_found = 1'b1;
                w_next_idx   = r_sel_idx + ADDR_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (!i_enable) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle, StDirect: begin
                    if (i_mode) begin
                        w_state_d = StScan;
                    end else if (i_load) begin
                        w_state_d = StDirect;
                    end
                end
                StScan: begin
                    if (!i_mode) begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_idx_d   = r_sel_idx;
        w_act_d   = r_valid;
        w_wrap_d  = 1'b0;
        w_cnt_d   = r_cnt;
        w_dwell_d = r_dwell;
        if (!i_enable) begin
            w_idx_d = '0;
            w_act_d = 1'b0;
            w_cnt_d = '0;
        end else begin
            case (r_state)
                StIdle, StDirect: begin
                    if (i_mode) begin
                        w_idx_d   = w_first_idx;
                        w_act_d   = w_first_found;
                        w_dwell_d = i_dwell;
                        w_cnt_d   = '0;
                    end else if (i_load) begin
                        w_idx_d = i_addr_in;
                        w_act_d = 1'b1;
                    end
                end
                StScan: begin
                    if (!i_mode) begin
                        w_idx_d = '0;
                        w_act_d = 1'b0;
                        w_cnt_d = '0;
                    end else if (!r_valid) begin
                        // Everything was masked; pick up as soon as an index frees up.
                        w_idx_d   = w_first_idx;
                        w_act_d   = w_first_found;
                        w_dwell_d = i_dwell;
                        w_cnt_d   = '0;
                    end else if (r_cnt < r_dwell) begin
                        w_cnt_d = r_cnt + DWELL_W'(1);
                    end else if (w_next_found) begin
                        w_idx_d   = w_next_idx;
                        w_wrap_d  = (w_next_idx <= r_sel_idx);
                        w_dwell_d = i_dwell;
                        w_cnt_d   = '0;
                    end else begin
                        w_idx_d = '0;
                        w_act_d = 1'b0;
                        w_cnt_d = '0;
                    end
                end
                default: begin
                    w_idx_d = '0;
                    w_act_d = 1'b0;
                    w_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_out <= '0;
            r_sel_idx <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_cnt     <= '0;
            r_dwell   <= '0;
        end else begin
            r_sel_out <= w_act_d ? (OUT_W'(1) << w_idx_d) : '0;
            r_sel_idx <= w_idx_d;
            r_valid   <= w_act_d;
            r_wrap    <= w_wrap_d;
            r_cnt     <= w_cnt_d;
            r_dwell   <= w_dwell_d;
        end
    end

    assign o_sel_out   = r_sel_out;
    assign o_sel_idx   = r_sel_idx;
    assign o_valid_out = r_valid;
    assign o_wrap      = r_wrap;

endmodule
